// File: rtl/wb_slave_regfile_pipe.sv
// Wishbone B4 pipelined slave register file with byte-lane writes, read-only
// status registers, a hardware update port and a fixed-latency response pipeline.
module wb_slave_regfile_pipe #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int GRANULE      = 8,
    parameter int REGISTER_NUM = 16,
    parameter logic [REGISTER_NUM-1:0]            READ_ONLY_MASK = '0,
    parameter logic [REGISTER_NUM*DATA_WIDTH-1:0] RESET_VALUE    = '0,
    parameter int WAIT_STATES  = 0,
    localparam int SEL_WIDTH   = DATA_WIDTH / GRANULE
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               cyc_i,
    input  logic                               stb_i,
    input  logic                               we_i,
    input  logic [ADDR_WIDTH-1:0]              adr_i,
    input  logic [DATA_WIDTH-1:0]              dat_i,
    input  logic [SEL_WIDTH-1:0]               sel_i,
    output logic [DATA_WIDTH-1:0]              dat_o,
    output logic                               ack_o,
    output logic                               err_o,
    output logic                               stall_o,
    output logic [REGISTER_NUM*DATA_WIDTH-1:0] regs_o,
    output logic [REGISTER_NUM-1:0]            wr_pulse_o,
    input  logic [REGISTER_NUM-1:0]            hw_we_i,
    input  logic [REGISTER_NUM*DATA_WIDTH-1:0] hw_dat_i
);

    localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH + 1)'(REGISTER_NUM);

    logic [DATA_WIDTH-1:0]   regs [REGISTER_NUM];
    logic                    accept;
    logic                    addr_err;
    logic                    ro_hit;
    logic                    resp_err;
    logic [REGISTER_NUM-1:0] hit;
    logic [REGISTER_NUM-1:0] bus_wr;
    logic [DATA_WIDTH-1:0]   lane_mask;
    logic [DATA_WIDTH-1:0]   read_word;
    logic [DATA_WIDTH-1:0]   read_data;

    logic [WAIT_STATES:0]    pipe_valid;
    logic [WAIT_STATES:0]    pipe_err;
    logic [DATA_WIDTH-1:0]   pipe_data [WAIT_STATES+1];

    // The response pipeline never backpressures; only reset holds the bus off.
    assign stall_o = rst_i;
    assign accept  = cyc_i & stb_i & ~stall_o;

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < SEL_WIDTH; i++) begin
            lane_mask[i*GRANULE +: GRANULE] = {GRANULE{sel_i[i]}};
        end
    end

    always_comb begin
        hit       = '0;
        read_word = '0;
        ro_hit    = 1'b0;
        for (int n = 0; n < REGISTER_NUM; n++) begin
            if (adr_i == ADDR_WIDTH'(n)) begin
                hit[n]    = 1'b1;
                read_word = regs[n];
                ro_hit    = READ_ONLY_MASK[n];
            end
        end
    end

    // Out-of-range addresses and writes to status registers terminate with ERR.
    always_comb begin
        addr_err  = ({1'b0, adr_i} >= REG_LIMIT);
        resp_err  = addr_err | (we_i & ro_hit);
        bus_wr    = (accept & we_i & ~resp_err) ? hit : '0;
        read_data = (we_i | resp_err) ? '0 : (read_word & lane_mask);
    end

    // A bus write takes priority over the hardware port on writable registers;
    // status registers follow hw_dat_i every cycle.
    always_ff @(posedge clk_i) begin
        for (int n = 0; n < REGISTER_NUM; n++) begin
            if (rst_i) begin
                regs[n] <= RESET_VALUE[n*DATA_WIDTH +: DATA_WIDTH];
            end else if (READ_ONLY_MASK[n]) begin
                regs[n] <= hw_dat_i[n*DATA_WIDTH +: DATA_WIDTH];
            end else if (bus_wr[n]) begin
                regs[n] <= (regs[n] & ~lane_mask) | (dat_i & lane_mask);
            end else if (hw_we_i[n]) begin
                regs[n] <= hw_dat_i[n*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_pulse_o <= '0;
        end else begin
            wr_pulse_o <= bus_wr;
        end
    end

    // Dropping cyc_i kills every in-flight response at the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_valid <= '0;
            pipe_err   <= '0;
            for (int i = 0; i <= WAIT_STATES; i++) begin
                pipe_data[i] <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_err[0]   <= resp_err;
            pipe_data[0]  <= read_data;
            for (int i = 1; i <= WAIT_STATES; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
            if (!cyc_i) begin
                pipe_valid <= '0;
            end
        end
    end

    assign ack_o = pipe_valid[WAIT_STATES] & ~pipe_err[WAIT_STATES];
    assign err_o = pipe_valid[WAIT_STATES] &  pipe_err[WAIT_STATES];
    assign dat_o = ack_o ? pipe_data[WAIT_STATES] : '0;

    always_comb begin
        regs_o = '0;
        for (int n = 0; n < REGISTER_NUM; n++) begin
            regs_o[n*DATA_WIDTH +: DATA_WIDTH] = regs[n];
        end
    end

endmodule

// File: tb/tb_wb_slave_regfile_pipe.sv
// Bench for wb_slave_regfile_pipe: two instances (zero and three wait states)
// share one bus; each has its own scoreboard of timed expected responses.
module tb_wb_slave_regfile_pipe;

    localparam int RESP_NONE = 0;
    localparam int RESP_ACK  = 1;
    localparam int RESP_ERR  = 2;
    localparam logic [511:0] RV = {384'h0, 32'hDEADBEEF, 96'h0};

    typedef struct {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [15:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          kind;
        logic [31:0] exp_dat;
    } vec_t;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] dat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, cyc, stb, we;
    logic [15:0]  adr;
    logic [31:0]  dat;
    logic [3:0]   sel;
    logic [15:0]  hw_we;
    logic [511:0] hw_dat;

    logic [31:0]  dat0, dat3;
    logic         ack0, ack3, err0, err3, stall0, stall3;
    logic [511:0] regs0, regs3;
    logic [15:0]  pulse0, pulse3;

    exp_t q0[$];
    exp_t q3[$];
    vec_t tbl[14];

    int edge_cnt    = 0;
    int compared    = 0;
    int mismatched  = 0;
    int pulse_tot0  = 0;
    int pulse_tot3  = 0;
    int pulse5_cnt  = 0;
    int ack3_cnt    = 0;
    int ack3_before = 0;

    always #5 clk = ~clk;

    wb_slave_regfile_pipe #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .GRANULE(8), .REGISTER_NUM(16),
        .READ_ONLY_MASK(16'h0004), .RESET_VALUE(RV), .WAIT_STATES(0)
    ) dut0 (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we),
        .adr_i(adr), .dat_i(dat), .sel_i(sel), .dat_o(dat0), .ack_o(ack0),
        .err_o(err0), .stall_o(stall0), .regs_o(regs0), .wr_pulse_o(pulse0),
        .hw_we_i(hw_we), .hw_dat_i(hw_dat)
    );

    wb_slave_regfile_pipe #(
        .ADDR_WIDTH(16), .DATA_WIDTH(32), .GRANULE(8), .REGISTER_NUM(16),
        .READ_ONLY_MASK(16'h0004), .RESET_VALUE(RV), .WAIT_STATES(3)
    ) dut3 (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we),
        .adr_i(adr), .dat_i(dat), .sel_i(sel), .dat_o(dat3), .ack_o(ack3),
        .err_o(err3), .stall_o(stall3), .regs_o(regs3), .wr_pulse_o(pulse3),
        .hw_we_i(hw_we), .hw_dat_i(hw_dat)
    );

    task automatic checkValue(input string nm, input logic [511:0] act, input logic [511:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic compareResp(input string nm, input logic have, input exp_t e,
                               input logic a, input logic er, input logic [31:0] d);
        logic        exp_ack, exp_err;
        logic [31:0] exp_d;
        exp_ack = have & ~e.err;
        exp_err = have & e.err;
        exp_d   = (have && !e.err) ? e.dat : 32'h0;
        compared++;
        if ({a, er, d} !== {exp_ack, exp_err, exp_d}) begin
            mismatched++;
            $display("[TB] FAIL %s resp @edge %0d: got ack=%b err=%b dat=%h, want ack=%b err=%b dat=%h",
                     nm, edge_cnt, a, er, d, exp_ack, exp_err, exp_d);
        end
    endtask

    // Sampled at the falling edge following each rising edge.
    task automatic checkOutput();
        exp_t e;
        logic have;
        have = 1'b0;
        e = '{0, 1'b0, 32'h0};
        if (q0.size() > 0 && q0[0].due == edge_cnt) begin
            e = q0.pop_front();
            have = 1'b1;
        end
        compareResp("dut0", have, e, ack0, err0, dat0);
        have = 1'b0;
        e = '{0, 1'b0, 32'h0};
        if (q3.size() > 0 && q3[0].due == edge_cnt) begin
            e = q3.pop_front();
            have = 1'b1;
        end
        compareResp("dut3", have, e, ack3, err3, dat3);
        pulse_tot0 += $countones(pulse0);
        pulse_tot3 += $countones(pulse3);
        pulse5_cnt += int'(pulse0[5]);
        ack3_cnt   += int'(ack3);
    endtask

    // Drives one bus cycle; responses pending at an abort or reset edge are discarded.
    task automatic applyStimulus(input logic c, input logic s, input logic w,
                                 input logic [15:0] a, input logic [31:0] d,
                                 input logic [3:0] sl, input int kind,
                                 input logic [31:0] ed);
        cyc = c; stb = s; we = w; adr = a; dat = d; sel = sl;
        if (!c || rst) begin
            while (q0.size() > 0 && q0[$].due >= edge_cnt + 1) void'(q0.pop_back());
            while (q3.size() > 0 && q3[$].due >= edge_cnt + 1) void'(q3.pop_back());
        end
        if (kind != RESP_NONE) begin
            q0.push_back('{edge_cnt + 1, kind == RESP_ERR, ed});
            q3.push_back('{edge_cnt + 4, kind == RESP_ERR, ed});
        end
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input logic c, input int n);
        for (int i = 0; i < n; i++) applyStimulus(c, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0, RESP_NONE, 32'h0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 16'd5,    32'h11223344, 4'hF, RESP_ACK, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 16'd5,    32'hAABBCCDD, 4'h5, RESP_ACK, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 16'd5,    32'h0,        4'hF, RESP_ACK, 32'h11BB33DD};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 16'd16,   32'h0,        4'hF, RESP_ERR, 32'h0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 32'h12345678, 4'hF, RESP_ERR, 32'h0};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 16'd2,    32'h12345678, 4'hF, RESP_ERR, 32'h0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 16'd2,    32'h0,        4'hF, RESP_ACK, 32'h0000C0DE};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 16'd5,    32'h0,        4'h3, RESP_ACK, 32'h000033DD};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 16'd9,    32'hCAFEF00D, 4'h0, RESP_ACK, 32'h0};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 16'd9,    32'h0,        4'hF, RESP_ACK, 32'h0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 16'd9,    32'hCAFEF00D, 4'hC, RESP_ACK, 32'h0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 16'd9,    32'h0,        4'hF, RESP_ACK, 32'hCAFE0000};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 16'd3,    32'h0,        4'h8, RESP_ACK, 32'hDE000000};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 16'd3,    32'h0,        4'hF, RESP_NONE, 32'h0};

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; dat = '0; sel = '0; hw_we = '0; hw_dat = '0;
        idle(1'b0, 2);
        checkValue("stall0 in reset", {511'h0, stall0}, 512'h1);
        checkValue("stall3 in reset", {511'h0, stall3}, 512'h1);
        checkValue("regs0 reset", regs0, RV);
        checkValue("pulse0 reset", {496'h0, pulse0}, 512'h0);
        rst = 1'b0;
        idle(1'b0, 1);
        checkValue("stall0 after reset", {511'h0, stall0}, 512'h0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 16'(i), 32'h0, 4'hF, RESP_ACK,
                          (i == 3) ? 32'hDEADBEEF : 32'h0);
        end
        idle(1'b1, 4);

        hw_dat[2*32 +: 32] = 32'h0000C0DE;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(tbl[i].cyc, tbl[i].stb, tbl[i].we, tbl[i].adr, tbl[i].dat,
                          tbl[i].sel, tbl[i].kind, tbl[i].exp_dat);
        end
        idle(1'b1, 4);
        checkValue("regs0 reg5", {480'h0, regs0[5*32 +: 32]}, {480'h0, 32'h11BB33DD});
        checkValue("regs3 reg5", {480'h0, regs3[5*32 +: 32]}, {480'h0, 32'h11BB33DD});
        checkValue("regs0 reg2 status", {480'h0, regs0[2*32 +: 32]}, {480'h0, 32'h0000C0DE});
        checkValue("regs0 reg15 untouched", {480'h0, regs0[15*32 +: 32]}, 512'h0);
        checkValue("regs0 reg9", {480'h0, regs0[9*32 +: 32]}, {480'h0, 32'hCAFE0000});
        checkValue("pulse reg5 count", 512'(pulse5_cnt), 512'd2);
        checkValue("pulse0 total", 512'(pulse_tot0), 512'd4);
        checkValue("pulse3 total", 512'(pulse_tot3), 512'd4);

        hw_we[7] = 1'b1;
        hw_dat[7*32 +: 32] = 32'h5;
        applyStimulus(1'b1, 1'b1, 1'b1, 16'd7, 32'h9, 4'hF, RESP_ACK, 32'h0);
        checkValue("bus beats hw reg7", {480'h0, regs0[7*32 +: 32]}, {480'h0, 32'h9});
        idle(1'b1, 1);
        checkValue("hw update reg7", {480'h0, regs0[7*32 +: 32]}, {480'h0, 32'h5});
        checkValue("hw update reg7 dut3", {480'h0, regs3[7*32 +: 32]}, {480'h0, 32'h5});
        hw_we[7] = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd7, 32'h0, 4'hF, RESP_ACK, 32'h5);
        idle(1'b1, 4);

        // Four pipelined reads, cyc_i dropped two cycles after the last accept.
        ack3_before = ack3_cnt;
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd3, 32'h0, 4'hF, RESP_ACK, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd5, 32'h0, 4'hF, RESP_ACK, 32'h11BB33DD);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd7, 32'h0, 4'hF, RESP_ACK, 32'h5);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd9, 32'h0, 4'hF, RESP_ACK, 32'hCAFE0000);
        idle(1'b1, 1);
        idle(1'b0, 6);
        checkValue("abort ack3 count", 512'(ack3_cnt - ack3_before), 512'd2);

        // Reset while two responses are in flight on the wait-state instance.
        ack3_before = ack3_cnt;
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd3, 32'h0, 4'hF, RESP_ACK, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd5, 32'h0, 4'hF, RESP_ACK, 32'h11BB33DD);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 16'd5, 32'h0, 4'hF, RESP_NONE, 32'h0);
        checkValue("stall0 mid reset", {511'h0, stall0}, 512'h1);
        checkValue("stall3 mid reset", {511'h0, stall3}, 512'h1);
        checkValue("regs0 after reset", regs0, RV);
        checkValue("regs3 after reset", regs3, RV);
        rst = 1'b0;
        idle(1'b1, 6);
        checkValue("no ack3 after reset", 512'(ack3_cnt - ack3_before), 512'd0);
        checkValue("queues drained", 512'(q0.size() + q3.size()), 512'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wb_slave_regfile_pipe.md
Name: wb_slave_regfile_pipe

Overview:
Wishbone B4 pipelined-mode slave holding REGISTER_NUM registers of DATA_WIDTH bits with byte-lane writes, per-register read-only/writable mode, per-register reset values and a hardware-side update port. It accepts one request per clock and answers each with exactly one ACK or ERR after a fixed, parametrised latency. It is the next-generation control/status register block sitting behind the Wishbone interconnect, between a bus master and peripheral logic.

Parameters:
ADDR_WIDTH, 16, word address width; adr_i = 0 selects register 0, 1 selects register 1, independent of DATA_WIDTH
DATA_WIDTH, 32, register and port width: 8, 16, 32 or 64
GRANULE, 8, byte-lane size, 8/16/32/64, divides DATA_WIDTH; SEL_WIDTH = DATA_WIDTH/GRANULE
REGISTER_NUM, 16, register count, 1..2**ADDR_WIDTH
READ_ONLY_MASK, 0, REGISTER_NUM-bit mask; bit n = 1 makes register n read-only (status)
RESET_VALUE, 0, REGISTER_NUM*DATA_WIDTH flattened reset values; register n uses slice [n*DATA_WIDTH +: DATA_WIDTH]
WAIT_STATES, 0, extra response latency 0..7

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
cyc_i  in  1  bus cycle valid
stb_i  in  1  request strobe
we_i  in  1  1 = write, 0 = read
adr_i  in  ADDR_WIDTH  register index
dat_i  in  DATA_WIDTH  write data
sel_i  in  SEL_WIDTH  byte-lane select, bit i covers [i*GRANULE +: GRANULE]
dat_o  out  DATA_WIDTH  read data, valid with ack_o
ack_o  out  1  normal termination
err_o  out  1  error termination
stall_o  out  1  pipeline stall
regs_o  out  REGISTER_NUM*DATA_WIDTH  current value of all registers, flattened
wr_pulse_o  out  REGISTER_NUM  one-cycle pulse per register written by the bus
hw_we_i  in  REGISTER_NUM  hardware update enable, one per register
hw_dat_i  in  REGISTER_NUM*DATA_WIDTH  hardware update data, flattened

Behaviour:
- Reset (rst_i = 1 at a clock edge): registers <= RESET_VALUE; response pipeline cleared; ack_o = err_o = 0, dat_o = 0, wr_pulse_o = 0. stall_o = 1 combinationally while rst_i is high, otherwise 0. Reset mid-transaction discards all pending responses; no ACK/ERR is issued for them.
- Accept: request accepted at an edge when cyc_i & stb_i & ~stall_o. Back-to-back accepts every cycle.
- Classification at accept: adr_i >= REGISTER_NUM -> ERR. Write to a register with READ_ONLY_MASK bit set -> ERR, no state change. Otherwise -> ACK.
- Write commit: performed at the accept edge; only lanes with sel_i set are updated. wr_pulse_o[adr] = 1 for the following cycle. sel_i = 0 is ACKed with no change and still pulses wr_pulse_o.
- Read capture: at the accept edge, from the register value before that edge. A write at cycle N followed by a read of the same register at N+1 returns the new data. dat_o lanes with sel_i clear read 0.
- Latency: ack_o/err_o high for exactly one cycle, 1+WAIT_STATES cycles after the accept edge, in request order. dat_o carries the read data in that cycle and is 0 in all other cycles, including write and ERR responses.
- Response pipeline: WAIT_STATES+1 stage shift register of {valid, err, data}; it never backpressures, so stall_o stays 0 outside reset.
- Abort: cyc_i = 0 clears every pending response valid bit in the same edge, so no ACK/ERR appears afterwards. Writes already committed remain committed.
- Hardware port: for a writable register, hw_we_i[n] loads the full hw_dat_i slice at the edge. If a bus write commits to the same register in the same cycle, the bus write wins entirely and the hardware update is dropped. Read-only registers load hw_dat_i[n] every cycle regardless of hw_we_i, and reads return the value registered at the previous edge.
- regs_o is driven directly from register flops, with no extra latency.

Test Plan:
- Reset, then read all 16 registers back-to-back with RESET_VALUE reg3 = 0xDEADBEEF, WAIT_STATES = 0 -> 16 consecutive ack_o, one per cycle starting 1 cycle after the first accept; reg3 returns 0xDEADBEEF, the others 0; err_o stays 0.
- Write reg5 = 0x11223344 with sel = 0xF, then write 0xAABBCCDD with sel = 0x5, then read reg5 -> returns 0x11BB33DD; wr_pulse_o[5] pulses twice; regs_o slice 5 matches.
- Read adr 16 and write adr 0xFFFF with REGISTER_NUM = 16; also write reg2 with READ_ONLY_MASK bit 2 set -> err_o for each, ack_o = 0, dat_o = 0, no register change.
- WAIT_STATES = 3: issue 4 pipelined reads, then drop cyc_i 2 cycles after the last accept -> the first 2 ACKs appear at accept+4 and accept+5; the remaining ACKs never appear.
- Same-cycle hw_we_i[7] = 1 with hw_dat_i = 0x5 and a bus write 0x9 to reg7 -> reg7 = 0x9. Next cycle hw_we_i[7] alone -> reg7 = 0x5.
- Assert rst_i for one cycle while 2 responses are pending (WAIT_STATES = 2) -> stall_o = 1 during reset, no ACK emitted, and all registers return to RESET_VALUE.
